// File: rtl/ntt_pkg.sv
// Shared constants, bank-state encoding and index helper for the NTT
// coefficient loader.
package ntt_pkg;

  localparam int NTT_N     = 16;
  localparam int NTT_W     = 8;
  localparam int NTT_LOG2N = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // Reverse the low nbits bits of idx; higher bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) begin
        r[nbits - 1 - i] = idx[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_coeff_loader_if.sv
// Coefficient stream in, parallel frame out. The loader connects through
// the slave modport; the coefficient source / frame sink uses master.
interface ntt_coeff_loader_if
  import ntt_pkg::*;
#(
  parameter int N = NTT_N,
  parameter int W = NTT_W
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           in_first;
  logic           frame_valid;
  logic           frame_ready;
  logic [N*W-1:0] frame_data;

  modport master (
    output in_valid, in_data, in_first, frame_ready,
    input  in_ready, frame_valid, frame_data
  );

  modport slave (
    input  in_valid, in_data, in_first, frame_ready,
    output in_ready, frame_valid, frame_data
  );

endinterface

// File: rtl/ntt_coeff_bank.sv
// One N x W coefficient register bank: single write port, full flat read-out.
// Contents are intentionally not reset; validity is tracked by the loader.
module ntt_coeff_bank
  import ntt_pkg::*;
#(
  parameter int N = NTT_N,
  parameter int W = NTT_W
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] widx,
  input  logic [W-1:0]         wdata,
  output logic [N*W-1:0]       rdata
);

  logic [N*W-1:0] data_r;

  // Write one coefficient slot when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      data_r[widx*W +: W] <= wdata;
    end
  end

  assign rdata = data_r;

endmodule

// File: rtl/ntt_coeff_loader.sv
// Ping-pong frame assembler feeding the 16-point NTT core. Coefficients are
// reduced mod q on entry and collected into two alternating banks; a full
// bank is presented on frame_data until consumed.
// Optional build macro NTT_LOADER_BITREV_EN: write coefficients at the
// bit-reversed index (iterative butterfly core) instead of natural order.
module ntt_coeff_loader
  import ntt_pkg::*;
#(
  parameter int N = NTT_N,
  parameter int W = NTT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         q,
  ntt_coeff_loader_if.slave    bus,
  output logic                 err
);

  localparam int LOG2N = $clog2(N);

  bank_state_t      st_r     [2];
  bank_state_t      st_nxt_s [2];
  logic             wr_sel_r, wr_sel_nxt_s;
  logic             rd_sel_r, rd_sel_nxt_s;
  logic [LOG2N-1:0] wr_cnt_r, wr_cnt_nxt_s;
  logic             err_r, err_nxt_s;
  logic             in_ready_r;
  logic             frame_valid_r;

  logic             accept_s;
  logic             consume_s;
  logic [LOG2N-1:0] seq_s;
  logic [LOG2N-1:0] wr_idx_s;
  logic [W-1:0]     red_s;
  logic [1:0]       we_s;
  logic [N*W-1:0]   rdata_s [2];

  // Handshakes, reduction, write index and next bank/pointer state.
  always_comb begin
    accept_s  = bus.in_valid && in_ready_r;
    consume_s = frame_valid_r && bus.frame_ready;
    red_s     = bus.in_data % q;
    // in_first always restarts the sequence at index 0.
    seq_s     = bus.in_first ? {LOG2N{1'b0}} : wr_cnt_r;
`ifdef NTT_LOADER_BITREV_EN
    wr_idx_s  = LOG2N'(bitrev(32'(seq_s), LOG2N));
`else
    wr_idx_s  = seq_s;
`endif
    we_s[0]   = accept_s && !wr_sel_r;
    we_s[1]   = accept_s &&  wr_sel_r;

    st_nxt_s     = st_r;
    wr_sel_nxt_s = wr_sel_r;
    rd_sel_nxt_s = rd_sel_r;
    wr_cnt_nxt_s = wr_cnt_r;
    err_nxt_s    = err_r;

    // A consume only ever touches a FULL bank, an accept only a non-FULL
    // one, so both may update different banks in the same cycle.
    if (consume_s) begin
      st_nxt_s[rd_sel_r] = EMPTY;
      rd_sel_nxt_s       = ~rd_sel_r;
    end else begin
      rd_sel_nxt_s = rd_sel_r;
    end

    if (accept_s) begin
      wr_cnt_nxt_s = seq_s + LOG2N'(1);
      if (seq_s == LOG2N'(N - 1)) begin
        st_nxt_s[wr_sel_r] = FULL;
        wr_sel_nxt_s       = ~wr_sel_r;
      end else begin
        st_nxt_s[wr_sel_r] = FILLING;
      end
      if (bus.in_first && (wr_cnt_r != {LOG2N{1'b0}})) begin
        err_nxt_s = 1'b1;
      end else begin
        err_nxt_s = err_r;
      end
    end else begin
      wr_cnt_nxt_s = wr_cnt_r;
    end
  end

  // Register bank states, pointers, sticky error and the handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r[0]       <= EMPTY;
      st_r[1]       <= EMPTY;
      wr_sel_r      <= 1'b0;
      rd_sel_r      <= 1'b0;
      wr_cnt_r      <= {LOG2N{1'b0}};
      err_r         <= 1'b0;
      in_ready_r    <= 1'b1;
      frame_valid_r <= 1'b0;
    end else begin
      st_r          <= st_nxt_s;
      wr_sel_r      <= wr_sel_nxt_s;
      rd_sel_r      <= rd_sel_nxt_s;
      wr_cnt_r      <= wr_cnt_nxt_s;
      err_r         <= err_nxt_s;
      in_ready_r    <= (st_nxt_s[wr_sel_nxt_s] != FULL);
      frame_valid_r <= (st_nxt_s[rd_sel_nxt_s] == FULL);
    end
  end

  ntt_coeff_bank #(.N(N), .W(W)) u_bank0 (
    .clk   (clk),
    .we    (we_s[0]),
    .widx  (wr_idx_s),
    .wdata (red_s),
    .rdata (rdata_s[0])
  );

  ntt_coeff_bank #(.N(N), .W(W)) u_bank1 (
    .clk   (clk),
    .we    (we_s[1]),
    .widx  (wr_idx_s),
    .wdata (red_s),
    .rdata (rdata_s[1])
  );

  assign bus.in_ready    = in_ready_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.frame_data  = rd_sel_r ? rdata_s[1] : rdata_s[0];
  assign err             = err_r;

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Self-checking bench for ntt_coeff_loader: reduction table, directed
// multi-cycle sequences and a randomized run against a frame-queue model.
module tb_ntt_coeff_loader;
  import ntt_pkg::*;

  localparam int N = NTT_N;
  localparam int W = NTT_W;
  localparam int L = NTT_LOG2N;

  typedef logic [W-1:0] frame_t [N];
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [W-1:0] exp;
  } red_vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] q;
  logic         err;

  int n_vec = 0;
  int n_err = 0;

  // Model: completed frames awaiting consume, plus the partial frame.
  frame_t       fq [$];
  logic [W-1:0] cur [$];
  logic         m_err;

  red_vec_t     tbl [8];

  always #5 clk = ~clk;

  ntt_coeff_loader_if #(.N(N), .W(W)) bus ();

  ntt_coeff_loader #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q),
    .bus (bus.slave),
    .err (err)
  );

  function automatic int tb_rev(input int k);
    int r = 0;
    for (int i = 0; i < L; i++) r = (r * 2) + ((k >> i) & 1);
    return r;
  endfunction

  // Sequence index whose coefficient is expected on frame word j.
  function automatic int seq_of(input int j);
`ifdef NTT_LOADER_BITREV_EN
    return tb_rev(j);
`else
    return j;
`endif
  endfunction

  function automatic logic [N*W-1:0] exp_bus(input frame_t f);
    logic [N*W-1:0] b;
    for (int j = 0; j < N; j++) b[j*W +: W] = f[seq_of(j)];
    return b;
  endfunction

  task automatic check(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.frame_ready = 1'b0; bus.in_data = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    fq.delete(); cur.delete(); m_err = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic f,
                       input logic fr, output logic acc);
    logic   m_rdy, m_fv;
    frame_t tmp;
    bus.in_valid = v; bus.in_data = d; bus.in_first = f; bus.frame_ready = fr;
    m_rdy = (fq.size() < 2);
    m_fv  = (fq.size() > 0);
    check("in_ready", {{(N*W-1){1'b0}}, bus.in_ready}, {{(N*W-1){1'b0}}, m_rdy});
    check("frame_valid", {{(N*W-1){1'b0}}, bus.frame_valid}, {{(N*W-1){1'b0}}, m_fv});
    check("err", {{(N*W-1){1'b0}}, err}, {{(N*W-1){1'b0}}, m_err});
    if (m_fv) check("frame_data", bus.frame_data, exp_bus(fq[0]));
    acc = v && m_rdy;
    if (m_fv && fr) void'(fq.pop_front());
    if (acc) begin
      if (f) begin
        if (cur.size() != 0) m_err = 1'b1;
        cur.delete();
      end
      cur.push_back(d % q);
      if (cur.size() == N) begin
        for (int k = 0; k < N; k++) tmp[k] = cur[k];
        fq.push_back(tmp);
        cur.delete();
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic check_word(input string nm, input int j, input int exp);
    check(nm, {{((N-1)*W){1'b0}}, bus.frame_data[j*W +: W]}, {{((N-1)*W){1'b0}}, W'(exp)});
  endtask

  initial begin
    logic a;
    int   acc_cnt;

    tbl[0] = '{q: 8'd17,  d: 8'd200, exp: 8'd13};
    tbl[1] = '{q: 8'd17,  d: 8'd17,  exp: 8'd0};
    tbl[2] = '{q: 8'd17,  d: 8'd255, exp: 8'd0};
    tbl[3] = '{q: 8'd251, d: 8'd250, exp: 8'd250};
    tbl[4] = '{q: 8'd251, d: 8'd251, exp: 8'd0};
    tbl[5] = '{q: 8'd2,   d: 8'd255, exp: 8'd1};
    tbl[6] = '{q: 8'd255, d: 8'd254, exp: 8'd254};
    tbl[7] = '{q: 8'd1,   d: 8'd200, exp: 8'd0};

    rst = 1'b1; q = 8'd17;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.frame_ready = 1'b0; bus.in_data = '0;

    // Reset state and a natural 0..15 frame consumed immediately.
    do_reset();
    check("rst_in_ready", {{(N*W-1){1'b0}}, bus.in_ready}, {{(N*W-1){1'b0}}, 1'b1});
    check("rst_frame_valid", {{(N*W-1){1'b0}}, bus.frame_valid}, {(N*W){1'b0}});
    check("rst_err", {{(N*W-1){1'b0}}, err}, {(N*W){1'b0}});
    for (int i = 0; i < N; i++) cycle(1'b1, W'(i), i == 0, 1'b1, a);
    check("fv_latency", {{(N*W-1){1'b0}}, bus.frame_valid}, {{(N*W-1){1'b0}}, 1'b1});
    for (int k = 0; k < N; k++) check_word("order_word", k, seq_of(k));
    cycle(1'b0, '0, 1'b0, 1'b1, a);
    check("consumed", {{(N*W-1){1'b0}}, bus.frame_valid}, {(N*W){1'b0}});

    // Reduction table: one full frame of each value, check words 0 and N-1.
    for (int t = 0; t < 8; t++) begin
      q = tbl[t].q;
      do_reset();
      for (int i = 0; i < N; i++) cycle(1'b1, tbl[t].d, i == 0, 1'b0, a);
      check_word("reduce_w0", 0, int'(tbl[t].exp));
      check_word("reduce_wlast", N - 1, int'(tbl[t].exp));
      cycle(1'b0, '0, 1'b0, 1'b1, a);
    end

    // Back-pressure: 40 offered, 32 accepted, one consume reopens input.
    q = 8'd251;
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, W'(acc_cnt), acc_cnt == 0, 1'b0, a);
      if (a) acc_cnt++;
    end
    check("bp_accepted", (N*W)'(acc_cnt), (N*W)'(2 * N));
    check("bp_in_ready_low", {{(N*W-1){1'b0}}, bus.in_ready}, {(N*W){1'b0}});
    cycle(1'b0, '0, 1'b0, 1'b1, a);
    check("bp_reenable", {{(N*W-1){1'b0}}, bus.in_ready}, {{(N*W-1){1'b0}}, 1'b1});
    for (int k = 0; k < N; k++) check_word("bp_frame2_word", k, N + seq_of(k));
    cycle(1'b0, '0, 1'b0, 1'b1, a);

    // Resync: 5 beats, then in_first with 9, then 15 more beats.
    q = 8'd17;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(i + 1), i == 0, 1'b0, a);
    cycle(1'b1, 8'd9, 1'b1, 1'b0, a);
    check("resync_err", {{(N*W-1){1'b0}}, err}, {{(N*W-1){1'b0}}, 1'b1});
    for (int i = 0; i < N - 1; i++) cycle(1'b1, W'(i + 10), 1'b0, 1'b0, a);
    check_word("resync_w0", 0, 9);
    check("resync_err_sticky", {{(N*W-1){1'b0}}, err}, {{(N*W-1){1'b0}}, 1'b1});
    cycle(1'b0, '0, 1'b0, 1'b1, a);

    // Mid-frame reset after 7 beats, then 100..115 with q=251.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, W'(50 + i), i == 0, 1'b0, a);
    q = 8'd251;
    do_reset();
    for (int i = 0; i < N; i++) cycle(1'b1, W'(100 + i), i == 0, 1'b0, a);
    for (int k = 0; k < N; k++) check_word("midrst_word", k, 100 + seq_of(k));
    check("midrst_err", {{(N*W-1){1'b0}}, err}, {(N*W){1'b0}});
    cycle(1'b0, '0, 1'b0, 1'b1, a);
    check("midrst_empty", {{(N*W-1){1'b0}}, bus.frame_valid}, {(N*W){1'b0}});

    // Randomized traffic against the model.
    for (int r = 0; r < 3; r++) begin
      q = W'($urandom_range(255, 1));
      do_reset();
      for (int i = 0; i < 1500; i++) begin
        cycle($urandom_range(99, 0) < 75, W'($urandom), $urandom_range(99, 0) < 3,
              $urandom_range(99, 0) < 50, a);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
